// File: rtl/llc_access_ctrl.sv
// rtl/llc_access_ctrl.sv - LLC request sequencer: tag lookup, victim selection, writeback/fill, tag and PLRU update.
module llc_access_ctrl #(
  parameter int ASSOCIATIVITY = 16,
  parameter int INDEX         = 14,
  parameter int BYTE_OFFSET   = 6,
  parameter int TAG_BITS      = 32 - (INDEX + BYTE_OFFSET),
  localparam int WAY_BITS     = $clog2(ASSOCIATIVITY),
  localparam int P_LRU        = ASSOCIATIVITY - 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_op,
  input  logic [31:0]                        req_addr,
  output logic                               rsp_valid,
  output logic                               rsp_hit,
  output logic [WAY_BITS-1:0]                rsp_way,
  output logic                               tag_rd_en,
  output logic [INDEX-1:0]                   tag_rd_set,
  input  logic [ASSOCIATIVITY*TAG_BITS-1:0]  tag_rd_tags,
  input  logic [ASSOCIATIVITY-1:0]           tag_rd_valid,
  input  logic [ASSOCIATIVITY-1:0]           tag_rd_dirty,
  input  logic [P_LRU-1:0]                   tag_rd_plru,
  output logic                               tag_wr_en,
  output logic [INDEX-1:0]                   tag_wr_set,
  output logic [WAY_BITS-1:0]                tag_wr_way,
  output logic [TAG_BITS-1:0]                tag_wr_tag,
  output logic                               tag_wr_valid,
  output logic                               tag_wr_dirty,
  output logic                               tag_wr_plru_en,
  output logic [P_LRU-1:0]                   tag_wr_plru,
  output logic                               bus_valid,
  output logic                               bus_op,
  output logic [31:0]                        bus_addr,
  input  logic                               bus_done,
  output logic [31:0]                        hit_cnt,
  output logic [31:0]                        miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_WB, S_FILL, S_UPDATE, S_RESP
  } state_t;

  state_t                r_state, w_next;
  logic                  r_is_wr, r_is_inv;
  logic [INDEX-1:0]      r_set;
  logic [TAG_BITS-1:0]   r_tag;
  logic                  r_hit;
  logic [WAY_BITS-1:0]   r_way;
  logic [TAG_BITS-1:0]   r_sel_tag;
  logic                  r_sel_dirty;
  logic [P_LRU-1:0]      r_plru;
  logic [31:0]           r_hit_cnt, r_miss_cnt;

  logic                  w_hit, w_has_free;
  logic [WAY_BITS-1:0]   w_hit_way, w_free_way, w_victim, w_sel_way;
  logic [TAG_BITS-1:0]   w_sel_tag;
  logic                  w_sel_valid, w_sel_dirty;

  // Tree walk: bit 0 steers to the left child (2n+1), 1 to the right (2n+2).
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [P_LRU-1:0] p);
    logic [WAY_BITS-1:0] node, way;
    logic b;
    node = '0;
    way  = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b    = p[node];
      way  = {way[WAY_BITS-2:0], b};
      node = {node[WAY_BITS-2:0], 1'b0} + WAY_BITS'(1) + {{(WAY_BITS-1){1'b0}}, b};
    end
    return way;
  endfunction

  function automatic logic [P_LRU-1:0] plru_touch(input logic [P_LRU-1:0] p,
                                                  input logic [WAY_BITS-1:0] way);
    logic [WAY_BITS-1:0] node, rem;
    logic [P_LRU-1:0] r;
    logic d;
    r    = p;
    node = '0;
    rem  = way;
    for (int l = 0; l < WAY_BITS; l++) begin
      d       = rem[WAY_BITS-1];
      r[node] = ~d;
      node    = {node[WAY_BITS-2:0], 1'b0} + WAY_BITS'(1) + {{(WAY_BITS-1){1'b0}}, d};
      rem     = rem << 1;
    end
    return r;
  endfunction

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (tag_rd_valid[w] && (tag_rd_tags[w*TAG_BITS +: TAG_BITS] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (!tag_rd_valid[w]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_BITS'(w);
      end
    end
    w_victim    = w_has_free ? w_free_way : plru_victim(tag_rd_plru);
    w_sel_way   = w_hit ? w_hit_way : w_victim;
    w_sel_tag   = '0;
    w_sel_valid = 1'b0;
    w_sel_dirty = 1'b0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (WAY_BITS'(w) == w_sel_way) begin
        w_sel_tag   = tag_rd_tags[w*TAG_BITS +: TAG_BITS];
        w_sel_valid = tag_rd_valid[w];
        w_sel_dirty = tag_rd_dirty[w];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_is_inv    <= 1'b0;
      r_set       <= '0;
      r_tag       <= '0;
      r_hit       <= 1'b0;
      r_way       <= '0;
      r_sel_tag   <= '0;
      r_sel_dirty <= 1'b0;
      r_plru      <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid) begin
        r_is_wr  <= (req_op == 2'd1);
        r_is_inv <= (req_op == 2'd2);
        r_set    <= req_addr[BYTE_OFFSET +: INDEX];
        r_tag    <= req_addr[31 -: TAG_BITS];
      end
      if (r_state == S_COMPARE) begin
        r_hit       <= w_hit;
        r_way       <= w_sel_way;
        r_sel_tag   <= w_sel_tag;
        r_sel_dirty <= w_sel_dirty;
        r_plru      <= tag_rd_plru;
      end
      if (r_state == S_UPDATE) begin
        if (r_hit)          r_hit_cnt  <= r_hit_cnt + 32'd1;
        else if (!r_is_inv) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    tag_rd_en      = 1'b0;
    tag_rd_set     = '0;
    tag_wr_en      = 1'b0;
    tag_wr_set     = '0;
    tag_wr_way     = '0;
    tag_wr_tag     = '0;
    tag_wr_valid   = 1'b0;
    tag_wr_dirty   = 1'b0;
    tag_wr_plru_en = 1'b0;
    tag_wr_plru    = '0;
    bus_valid      = 1'b0;
    bus_op         = 1'b0;
    bus_addr       = '0;
    rsp_valid      = 1'b0;
    rsp_hit        = 1'b0;
    rsp_way        = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        tag_rd_en  = 1'b1;
        tag_rd_set = r_set;
        w_next     = S_COMPARE;
      end
      S_COMPARE: begin
        if (r_is_inv)                  w_next = w_hit ? (w_sel_dirty ? S_WB : S_UPDATE) : S_RESP;
        else if (w_hit)                w_next = S_UPDATE;
        else if (w_sel_valid && w_sel_dirty) w_next = S_WB;
        else                           w_next = S_FILL;
      end
      S_WB: begin
        bus_valid = 1'b1;
        bus_op    = 1'b1;
        bus_addr  = {r_sel_tag, r_set, {BYTE_OFFSET{1'b0}}};
        if (bus_done) w_next = r_is_inv ? S_UPDATE : S_FILL;
      end
      S_FILL: begin
        bus_valid = 1'b1;
        bus_addr  = {r_tag, r_set, {BYTE_OFFSET{1'b0}}};
        if (bus_done) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        rsp_valid      = 1'b1;
        rsp_hit        = r_hit;
        rsp_way        = r_way;
        tag_wr_en      = 1'b1;
        tag_wr_set     = r_set;
        tag_wr_way     = r_way;
        tag_wr_tag     = r_hit ? r_sel_tag : r_tag;
        tag_wr_valid   = !r_is_inv;
        tag_wr_dirty   = r_is_inv ? 1'b0 : (r_hit ? (r_sel_dirty | r_is_wr) : r_is_wr);
        tag_wr_plru_en = !r_is_inv;
        tag_wr_plru    = r_is_inv ? '0 : plru_touch(r_plru, r_way);
        w_next         = S_IDLE;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_llc_access_ctrl.sv
// tb/tb_llc_access_ctrl.sv - directed vector bench for llc_access_ctrl.
module tb_llc_access_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [31:0]  req_addr;
  logic         rsp_valid, rsp_hit;
  logic [3:0]   rsp_way;
  logic         tag_rd_en;
  logic [13:0]  tag_rd_set;
  logic [191:0] tag_rd_tags;
  logic [15:0]  tag_rd_valid, tag_rd_dirty;
  logic [14:0]  tag_rd_plru;
  logic         tag_wr_en;
  logic [13:0]  tag_wr_set;
  logic [3:0]   tag_wr_way;
  logic [11:0]  tag_wr_tag;
  logic         tag_wr_valid, tag_wr_dirty, tag_wr_plru_en;
  logic [14:0]  tag_wr_plru;
  logic         bus_valid, bus_op;
  logic [31:0]  bus_addr;
  logic         bus_done;
  logic [31:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  llc_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .tag_rd_en(tag_rd_en), .tag_rd_set(tag_rd_set), .tag_rd_tags(tag_rd_tags),
    .tag_rd_valid(tag_rd_valid), .tag_rd_dirty(tag_rd_dirty), .tag_rd_plru(tag_rd_plru),
    .tag_wr_en(tag_wr_en), .tag_wr_set(tag_wr_set), .tag_wr_way(tag_wr_way),
    .tag_wr_tag(tag_wr_tag), .tag_wr_valid(tag_wr_valid), .tag_wr_dirty(tag_wr_dirty),
    .tag_wr_plru_en(tag_wr_plru_en), .tag_wr_plru(tag_wr_plru), .bus_valid(bus_valid),
    .bus_op(bus_op), .bus_addr(bus_addr), .bus_done(bus_done), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic [1:0]   op;
    logic [31:0]  addr;
    logic [191:0] tags;
    logic [15:0]  valid;
    logic [15:0]  dirty;
    logic [14:0]  plru;
    int           delay;
    int           nbus;
    logic         b0_op;
    logic [31:0]  b0_addr;
    logic         b1_op;
    logic [31:0]  b1_addr;
    logic         exp_wr;
    logic [3:0]   way;
    logic [11:0]  wtag;
    logic         wv;
    logic         wd;
    logic         wplru_en;
    logic [14:0]  wplru;
    logic         hit;
    int           rsp_cyc;
    logic [13:0]  set;
  } vec_t;

  vec_t vecs[14];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_hit = 0;
  logic [31:0] exp_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] tagset(input logic [11:0] base);
    logic [191:0] t;
    for (int w = 0; w < 16; w++) t[w*12 +: 12] = base + 12'(w);
    return t;
  endfunction

  function automatic logic [191:0] with_tag(input logic [191:0] t, input int w, input logic [11:0] tg);
    logic [191:0] r;
    r = t;
    r[w*12 +: 12] = tg;
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr, input logic [191:0] tags,
      input logic [15:0] valid, input logic [15:0] dirty, input logic [14:0] plru, input int delay,
      input int nbus, input logic b0op, input logic [31:0] b0a, input logic b1op, input logic [31:0] b1a,
      input logic ew, input logic [3:0] way, input logic [11:0] wtag, input logic wv, input logic wd,
      input logic wpe, input logic [14:0] wp, input logic hit, input int rc, input logic [13:0] set);
    vec_t v;
    v.op = op; v.addr = addr; v.tags = tags; v.valid = valid; v.dirty = dirty; v.plru = plru;
    v.delay = delay; v.nbus = nbus; v.b0_op = b0op; v.b0_addr = b0a; v.b1_op = b1op; v.b1_addr = b1a;
    v.exp_wr = ew; v.way = way; v.wtag = wtag; v.wv = wv; v.wd = wd; v.wplru_en = wpe; v.wplru = wp;
    v.hit = hit; v.rsp_cyc = rc; v.set = set;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int cnt, nbus, lk_cyc, wr_cyc, rsp_cyc;
    logic bop[2];
    logic [31:0] badr[2];
    logic [13:0] lk_set, wset;
    logic [3:0] wway, rway;
    logic [11:0] wtag;
    logic wv, wd, wpe, rhit, unstable, wr_seen;
    logic [14:0] wp;
    nbus = 0; lk_cyc = 0; wr_cyc = -1; rsp_cyc = -1; cnt = 0; unstable = 0; wr_seen = 0;
    bop[0] = 0; bop[1] = 0; badr[0] = 0; badr[1] = 0; lk_set = 0;
    wset = 0; wway = 0; wtag = 0; wv = 0; wd = 0; wpe = 0; wp = 0; rhit = 0; rway = 0;
    tag_rd_tags = v.tags; tag_rd_valid = v.valid; tag_rd_dirty = v.dirty; tag_rd_plru = v.plru;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    chk({nm, " ready_before"}, req_ready, 1);
    req_valid = 1; req_op = v.op; req_addr = v.addr;
    step();
    req_valid = 0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (bus_done) begin bus_done = 0; cnt = 0; end
      if (tag_rd_en) begin lk_cyc = cyc; lk_set = tag_rd_set; end
      if (bus_valid) begin
        if (cnt == 0) begin
          if (nbus < 2) begin bop[nbus] = bus_op; badr[nbus] = bus_addr; end
          nbus++;
        end else if (nbus <= 2 && (bus_op !== bop[nbus-1] || bus_addr !== badr[nbus-1])) unstable = 1;
        cnt++;
        if (cnt > v.delay) bus_done = 1;
      end
      if (tag_wr_en) begin
        wr_seen = 1; wr_cyc = cyc; wset = tag_wr_set; wway = tag_wr_way; wtag = tag_wr_tag;
        wv = tag_wr_valid; wd = tag_wr_dirty; wpe = tag_wr_plru_en; wp = tag_wr_plru;
      end
      if (rsp_valid) begin rsp_cyc = cyc; rhit = rsp_hit; rway = rsp_way; break; end
      step();
    end
    bus_done = 0;
    chk({nm, " rsp_seen"}, rsp_cyc > 0, 1);
    chk({nm, " lookup_cyc"}, lk_cyc, 1);
    chk({nm, " lookup_set"}, lk_set, v.set);
    chk({nm, " nbus"}, nbus, v.nbus);
    if (v.nbus >= 1) begin
      chk({nm, " bus0_op"}, bop[0], v.b0_op);
      chk({nm, " bus0_addr"}, badr[0], v.b0_addr);
    end
    if (v.nbus >= 2) begin
      chk({nm, " bus1_op"}, bop[1], v.b1_op);
      chk({nm, " bus1_addr"}, badr[1], v.b1_addr);
    end
    chk({nm, " bus_stable"}, unstable, 0);
    chk({nm, " wr_seen"}, wr_seen, v.exp_wr);
    if (v.exp_wr) begin
      chk({nm, " wr_cyc"}, wr_cyc, rsp_cyc);
      chk({nm, " wr_set"}, wset, v.set);
      chk({nm, " wr_way"}, wway, v.way);
      chk({nm, " wr_tag"}, wtag, v.wtag);
      chk({nm, " wr_valid"}, wv, v.wv);
      chk({nm, " wr_dirty"}, wd, v.wd);
      chk({nm, " wr_plru_en"}, wpe, v.wplru_en);
      if (v.wplru_en) chk({nm, " wr_plru"}, wp, v.wplru);
    end
    chk({nm, " rsp_hit"}, rhit, v.hit);
    chk({nm, " rsp_way"}, rway, v.exp_wr ? v.way : 4'd0);
    if (v.rsp_cyc > 0) chk({nm, " rsp_cyc"}, rsp_cyc, v.rsp_cyc);
    if (v.hit) exp_hit++;
    else if (v.op != 2'd2) exp_miss++;
    step();
    chk({nm, " ready_after"}, req_ready, 1);
    chk({nm, " rsp_pulse"}, rsp_valid, 0);
    chk({nm, " hit_cnt"}, hit_cnt, exp_hit);
    chk({nm, " miss_cnt"}, miss_cnt, exp_miss);
  endtask

  initial begin
    logic [191:0] t;
    t = tagset(12'h100);
    //           op   addr          tags                     valid     dirty     plru     dly nb b0 b0addr        b1 b1addr        wr way tag     v  d  pe plru     hit cyc set
    vecs[0]  = mk(0, 32'h0000_1040, '0,                      16'h0000, 16'h0000, 15'h0000, 0, 1, 0, 32'h0000_1040, 0, 0,            1, 0,  12'h000, 1, 0, 1, 15'h008B, 0, 4,  14'h41);
    vecs[1]  = mk(0, 32'h0000_1040, '0,                      16'h0001, 16'h0000, 15'h008B, 0, 0, 0, 0,            0, 0,            1, 0,  12'h000, 1, 0, 1, 15'h008B, 1, 3,  14'h41);
    vecs[2]  = mk(1, 32'h0010_1040, t,                       16'hFFFF, 16'h0000, 15'h0000, 0, 1, 0, 32'h0010_1040, 0, 0,            1, 0,  12'h001, 1, 1, 1, 15'h008B, 0, 4,  14'h41);
    vecs[3]  = mk(0, 32'h0020_1040, t,                       16'hFFFF, 16'h0001, 15'h0000, 5, 2, 1, 32'h1000_1040, 0, 32'h0020_1040, 1, 0,  12'h002, 1, 0, 1, 15'h008B, 0, 15, 14'h41);
    vecs[4]  = mk(0, 32'h0030_1040, t,                       16'hFFFF, 16'h0000, 15'h7FFF, 0, 1, 0, 32'h0030_1040, 0, 0,            1, 15, 12'h003, 1, 0, 1, 15'h3FBA, 0, 4,  14'h41);
    vecs[5]  = mk(1, 32'h0040_1040, t,                       16'hFFFF, 16'h0000, 15'h0202, 0, 1, 0, 32'h0040_1040, 0, 0,            1, 5,  12'h004, 1, 1, 1, 15'h0011, 0, 4,  14'h41);
    vecs[6]  = mk(0, 32'h0050_1040, t,                       16'hFFB7, 16'h0000, 15'h7FFF, 0, 1, 0, 32'h0050_1040, 0, 0,            1, 3,  12'h005, 1, 0, 1, 15'h7EF7, 0, 4,  14'h41);
    vecs[7]  = mk(1, 32'h0060_1040, with_tag(with_tag(with_tag(t, 1, 12'h006), 2, 12'h006), 7, 12'h006),
                                                             16'hFFFD, 16'h0000, 15'h0000, 0, 0, 0, 0,            0, 0,            1, 2,  12'h006, 1, 1, 1, 15'h0103, 1, 3,  14'h41);
    vecs[8]  = mk(0, 32'h0070_1040, with_tag(t, 9, 12'h007), 16'hFFFF, 16'h0201, 15'h0000, 0, 0, 0, 0,            0, 0,            1, 9,  12'h007, 1, 1, 1, 15'h0024, 1, 3,  14'h41);
    vecs[9]  = mk(2, 32'h0080_1040, with_tag(t, 3, 12'h008), 16'hFFFF, 16'h0008, 15'h0000, 0, 1, 1, 32'h0080_1040, 0, 0,            1, 3,  12'h008, 0, 0, 0, 15'h0000, 1, 4,  14'h41);
    vecs[10] = mk(2, 32'h0090_1040, with_tag(t, 12, 12'h009), 16'hFFFF, 16'h2000, 15'h0000, 0, 0, 0, 0,           0, 0,            1, 12, 12'h009, 0, 0, 0, 15'h0000, 1, 3,  14'h41);
    vecs[11] = mk(2, 32'h00B0_1040, t,                       16'hFFFF, 16'hFFFF, 15'h0000, 0, 0, 0, 0,            0, 0,            0, 0,  12'h000, 0, 0, 0, 15'h0000, 0, 3,  14'h41);
    vecs[12] = mk(3, 32'h00A0_1040, with_tag(t, 1, 12'h00A), 16'hFFFF, 16'h0000, 15'h0000, 0, 0, 0, 0,            0, 0,            1, 1,  12'h00A, 1, 0, 1, 15'h000B, 1, 3,  14'h41);
    vecs[13] = mk(0, 32'hABCD_E7FF, '0,                      16'h0000, 16'h0000, 15'h0000, 0, 1, 0, 32'hABCD_E7C0, 0, 0,            1, 0,  12'hABC, 1, 0, 1, 15'h008B, 0, 4,  14'h379F);

    rst = 1; req_valid = 0; req_op = 0; req_addr = 0; bus_done = 0;
    tag_rd_tags = '0; tag_rd_valid = '0; tag_rd_dirty = '0; tag_rd_plru = '0;
    step();
    step();
    chk("reset req_ready", req_ready, 0);
    chk("reset bus_valid", bus_valid, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset tag_rd_en", tag_rd_en, 0);
    chk("reset tag_wr_en", tag_wr_en, 0);
    chk("reset counters", {hit_cnt, miss_cnt}, 64'd0);
    rst = 0;
    step();
    chk("idle req_ready", req_ready, 1);

    for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while FILL is waiting for the bus.
    tag_rd_tags = '0; tag_rd_valid = '0; tag_rd_dirty = '0; tag_rd_plru = '0;
    req_valid = 1; req_op = 0; req_addr = 32'h0000_1040;
    step();
    req_valid = 0;
    for (int i = 0; i < 10 && !bus_valid; i++) step();
    step();
    step();
    chk("midrst bus_valid_before", bus_valid, 1);
    chk("midrst bus_op_before", bus_op, 0);
    #2 rst = 1;
    #1;
    chk("midrst bus_valid", bus_valid, 0);
    chk("midrst tag_wr_en", tag_wr_en, 0);
    chk("midrst rsp_valid", rsp_valid, 0);
    chk("midrst req_ready", req_ready, 0);
    chk("midrst counters", {hit_cnt, miss_cnt}, 64'd0);
    step();
    rst = 0;
    exp_hit = 0;
    exp_miss = 0;
    step();
    run_txn(vecs[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
